adat_encoder: RTL and testbench
===============================

Name: adat_encoder

Overview:
- ADAT Lightpipe transmitter. It is the counterpart of adat_decoder.
- It reads 24-bit samples for 8 channels from the 1-bit-wide channel_buffer circular RAM, formats 256-bit ADAT frames (sync, user bits, nibble-grouped samples) and drives an NRZI serial stream.
- Frame ownership is handed over through a frame index driven by the producer, which writes the RAM.

Parameters:
- CIRC_BUF_BITS, 3: log2 of the number of frames in the circular RAM. RAM address width is CIRC_BUF_BITS+8.
- CLKS_PER_BIT, 4: clk_i cycles per ADAT bit. Must be >= 2; RAM read latency depends on this.

Ports:
- clk_i  input  1  system clock.
- reset_ni  input  1  asynchronous active-low reset.
- tx_en_i  input  1  enable transmission; sampled only at frame boundaries.
- user_bits_i  input  4  user bits; sampled at frame start.
- write_frame_idx_i  input  CIRC_BUF_BITS  index of the last frame completely written by the producer.
- ram_read_addr_o  output  CIRC_BUF_BITS+8  RAM read address, laid out as {frame, channel[2:0], bit[4:0]}.
- ram_read_data_i  input  1  RAM read data, valid one clk_i after the address.
- nrzi_o  output  1  ADAT NRZI line.
- read_frame_idx_o  output  CIRC_BUF_BITS  frame currently being transmitted.
- frame_start_o  output  1  one-cycle pulse on the first clock of the first sync bit.
- underrun_o  output  1  one-cycle pulse, coincident with frame_start_o, when no new frame is available.
- busy_o  output  1  high while a frame is being transmitted.

Behaviour:
- Reset values: nrzi_o=0, ram_read_addr_o=0, read_frame_idx_o=0, frame_start_o=0, underrun_o=0, busy_o=0, state=IDLE, all counters 0.
- Reset is asynchronous and takes effect immediately, including mid-frame. After release the block restarts from IDLE.
- Bit timing: a divider counts 0..CLKS_PER_BIT-1. Each raw ADAT bit occupies exactly CLKS_PER_BIT cycles, so a frame is 256*CLKS_PER_BIT cycles.
- NRZI encoding: on divider count 0 of each bit, nrzi_o toggles if the raw bit is 1 and holds if it is 0.
- Frame layout, raw bits in order:
  - SYNC: 10 zeros, then a 1 (11 bits).
  - USER: user_bits_i[3], [2], [1], [0], then a 1 (5 bits).
  - DATA: channels 0..7, 30 bits each. Each channel is 6 groups of 4 sample bits, MSB first, and every group is followed by a separator 1. Total 256 bits.
- RAM mapping: sample bit b (0 = MSB, 0..23) of channel c is at address {read_frame_idx_o, c, b}. Slot bits 24..31 are never read.
- RAM read timing: the address for the next data bit is presented at divider count 0 of the preceding bit. ram_read_data_i is registered one cycle later. When not in DATA, ram_read_addr_o holds its last value.
- State machine: IDLE -> SYNC -> USER -> DATA.
  - IDLE -> SYNC when tx_en_i=1 at a divider wrap.
  - At the end of DATA, go to SYNC if tx_en_i=1, otherwise to IDLE.
  - DATA is tracked by a channel counter (0..7), a group counter (0..5) and a position counter (0..4); position 4 is the separator. No dividers or multipliers.
- Frame selection (evaluated on the clock where frame_start_o is asserted):
  - If read_frame_idx_o != write_frame_idx_i: read_frame_idx_o advances by 1, wrapping modulo 2^CIRC_BUF_BITS.
  - Otherwise: underrun_o pulses, the index is unchanged, and all 192 sample bits are transmitted as 0. Sync, user bits and separators are still sent.
- IDLE: nrzi_o holds its level with no toggles; busy_o=0.
- Deasserting tx_en_i mid-frame completes the current frame.
- user_bits_i and write_frame_idx_i are sampled only at frame start. Changes during a frame have no effect until the next frame.

Optional Feature:
- Macro: ADAT_ENCODER_REPEAT_ON_UNDERRUN_EN.
- Defined: on underrun, the frame at the unchanged read_frame_idx_o is re-read and retransmitted instead of muted. underrun_o still pulses.
- Undefined: underrun frames carry all-zero samples, as described under Behaviour.

Test Plan:
- Reset with tx_en_i=0 -> all outputs at reset values. After release, nrzi_o stays constant for 2000 cycles; frame_start_o never pulses.
- Sync pattern (CLKS_PER_BIT=4, tx_en_i=1, write_frame_idx_i=1) -> after frame_start_o, nrzi_o holds for 40 cycles, toggles at cycle 40, and frame_start_o recurs every 1024 cycles.
- Data content: RAM frame 1 ch0=0x800001, ch7=0xA5A5A5, other channels 0, user_bits_i=4'b1010 -> the NRZI-decoded raw frame equals the golden 256-bit vector. Looping nrzi_o through adat_decoder into a second channel_buffer reproduces the same 24-bit values.
- Underrun: write_frame_idx_i held at 1 -> the first frame plays frame 1, the second frame pulses underrun_o with zero samples (with the macro defined, frame 1 is repeated). read_frame_idx_o stays 1.
- Wrap-around: write_frame_idx_i advanced one frame ahead each frame for 10 frames -> read_frame_idx_o sequence 1..7,0,1,2 with no underrun_o.
- reset_ni low in mid-DATA -> outputs return to reset values in the same cycle. After release with tx_en_i=1, a clean SYNC starts at the next divider wrap.

Source files
------------

// File: rtl/adat_encoder.sv
// ADAT Lightpipe transmitter.
// Reads 8 x 24-bit samples per frame from a 1-bit-wide circular RAM, builds the
// 256-bit ADAT frame (sync, user bits, nibble-grouped samples with separator
// ones) and drives it out as an NRZI line, one raw bit per CLKS_PER_BIT clocks.
// Optional build macro ADAT_ENCODER_REPEAT_ON_UNDERRUN_EN: on underrun the frame
// at the unchanged read index is retransmitted instead of being muted.
//
// RAM interface: the address for a sample bit is registered on the clock that
// starts the preceding raw bit (divider count 0); the RAM returns data one
// clock later, and the bit is captured at divider count 1.
module adat_encoder #(
  parameter int CIRC_BUF_BITS = 3,
  parameter int CLKS_PER_BIT  = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       tx_en_i,
  input  logic [3:0]                 user_bits_i,
  input  logic [CIRC_BUF_BITS-1:0]   write_frame_idx_i,
  output logic [CIRC_BUF_BITS+7:0]   ram_read_addr_o,
  input  logic                       ram_read_data_i,
  output logic                       nrzi_o,
  output logic [CIRC_BUF_BITS-1:0]   read_frame_idx_o,
  output logic                       frame_start_o,
  output logic                       underrun_o,
  output logic                       busy_o
);

  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

`ifdef ADAT_ENCODER_REPEAT_ON_UNDERRUN_EN
  localparam logic MUTE_ON_UNDERRUN = 1'b0;
`else
  localparam logic MUTE_ON_UNDERRUN = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, SYNC, USER, DATA} state_e;

  state_e                     state_q, state_d;
  logic [DW-1:0]              div_q, div_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [2:0]                 ch_q, ch_d;
  logic [2:0]                 grp_q, grp_d;
  logic [2:0]                 pos_q, pos_d;
  logic [CIRC_BUF_BITS-1:0]   idx_q, idx_d;
  logic [3:0]                 user_q, user_d;
  logic                       mute_q, mute_d;
  logic                       sample_q, sample_d;
  logic                       nrzi_q, nrzi_d;
  logic [CIRC_BUF_BITS+7:0]   addr_q, addr_d;
  logic                       fs_q, fs_d;
  logic                       ur_q, ur_d;

  logic wrap;
  logic data_bit;
  logic sample_bit;
  logic raw;
  logic start;

  assign wrap = (div_q == DIV_LAST);
  // With CLKS_PER_BIT == 2 the capture cycle is also the wrap cycle, so the
  // RAM data is used straight from the port in that case.
  assign data_bit   = (div_q == DIV_ONE) ? ram_read_data_i : sample_q;
  assign sample_bit = data_bit & ~mute_q;

  // Next-state, raw-bit selection, NRZI and RAM address generation.
  always_comb begin
    state_d  = state_q;
    div_d    = wrap ? '0 : div_q + DW'(1);
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    grp_d    = grp_q;
    pos_d    = pos_q;
    idx_d    = idx_q;
    user_d   = user_q;
    mute_d   = mute_q;
    sample_d = sample_q;
    nrzi_d   = nrzi_q;
    addr_d   = addr_q;
    fs_d     = 1'b0;
    ur_d     = 1'b0;
    raw      = 1'b0;
    start    = 1'b0;

    if (div_q == DIV_ONE) sample_d = ram_read_data_i;

    if (wrap) begin
      case (state_q)
        IDLE: if (tx_en_i) start = 1'b1;
        SYNC: begin
          if (cnt_q == 4'd10) begin
            state_d = USER;
            cnt_d   = 4'd0;
            raw     = user_q[3];
            user_d  = {user_q[2:0], 1'b0};
          end else begin
            cnt_d = cnt_q + 4'd1;
            raw   = (cnt_q == 4'd9);
          end
        end
        USER: begin
          if (cnt_q == 4'd4) begin
            state_d = DATA;
            ch_d    = 3'd0;
            grp_d   = 3'd0;
            pos_d   = 3'd0;
            raw     = sample_bit;
          end else if (cnt_q == 4'd3) begin
            cnt_d = 4'd4;
            raw   = 1'b1;
          end else begin
            cnt_d  = cnt_q + 4'd1;
            raw    = user_q[3];
            user_d = {user_q[2:0], 1'b0};
          end
        end
        DATA: begin
          if (pos_q != 3'd4) begin
            pos_d = pos_q + 3'd1;
            raw   = (pos_q == 3'd3) ? 1'b1 : sample_bit;
          end else if (grp_q != 3'd5) begin
            grp_d = grp_q + 3'd1;
            pos_d = 3'd0;
            raw   = sample_bit;
          end else if (ch_q != 3'd7) begin
            ch_d  = ch_q + 3'd1;
            grp_d = 3'd0;
            pos_d = 3'd0;
            raw   = sample_bit;
          end else if (tx_en_i) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // Frame start: first sync bit (a zero), latch user bits, pick the frame.
      if (start) begin
        state_d = SYNC;
        cnt_d   = 4'd0;
        fs_d    = 1'b1;
        user_d  = user_bits_i;
        if (idx_q != write_frame_idx_i) begin
          idx_d  = idx_q + 1'b1;
          mute_d = 1'b0;
        end else begin
          ur_d   = 1'b1;
          mute_d = MUTE_ON_UNDERRUN;
        end
      end

      nrzi_d = nrzi_q ^ raw;

      // Present the address of the sample bit that follows the bit now starting.
      if (state_d == USER && cnt_d == 4'd4) begin
        addr_d = {idx_d, 3'd0, 5'd0};
      end else if (state_d == DATA && pos_d < 3'd3) begin
        addr_d = {idx_d, ch_d, {grp_d, 2'b00} + {2'b00, pos_d} + 5'd1};
      end else if (state_d == DATA && pos_d == 3'd4 && grp_d != 3'd5) begin
        addr_d = {idx_d, ch_d, {grp_d + 3'd1, 2'b00}};
      end else if (state_d == DATA && pos_d == 3'd4 && ch_d != 3'd7) begin
        addr_d = {idx_d, ch_d + 3'd1, 5'd0};
      end
    end
  end

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      ch_q     <= '0;
      grp_q    <= '0;
      pos_q    <= '0;
      idx_q    <= '0;
      user_q   <= '0;
      mute_q   <= 1'b0;
      sample_q <= 1'b0;
      nrzi_q   <= 1'b0;
      addr_q   <= '0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      grp_q    <= grp_d;
      pos_q    <= pos_d;
      idx_q    <= idx_d;
      user_q   <= user_d;
      mute_q   <= mute_d;
      sample_q <= sample_d;
      nrzi_q   <= nrzi_d;
      addr_q   <= addr_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
    end
  end

  assign nrzi_o           = nrzi_q;
  assign ram_read_addr_o  = addr_q;
  assign read_frame_idx_o = idx_q;
  assign frame_start_o    = fs_q;
  assign underrun_o       = ur_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_adat_encoder.sv
// Bench for adat_encoder: a frame-level model (256-entry raw-bit array built
// from the sample table) predicts the NRZI line and status outputs each cycle.
module tb_adat_encoder;

  localparam int CB = 3;
  localparam int C  = 4;
  localparam int FRAME_CYC = 256 * C;

`ifdef ADAT_ENCODER_REPEAT_ON_UNDERRUN_EN
  localparam bit MUTE = 1'b0;
`else
  localparam bit MUTE = 1'b1;
`endif

  logic          clk;
  logic          rst_n;
  logic          tx_en;
  logic [3:0]    user_bits;
  logic [CB-1:0] w_idx;
  logic [CB+7:0] ram_addr;
  logic          ram_rd;
  logic          nrzi;
  logic [CB-1:0] r_idx;
  logic          fs;
  logic          ur;
  logic          busy;

  adat_encoder #(.CIRC_BUF_BITS(CB), .CLKS_PER_BIT(C)) dut (
    .clk_i(clk), .reset_ni(rst_n), .tx_en_i(tx_en), .user_bits_i(user_bits),
    .write_frame_idx_i(w_idx), .ram_read_addr_o(ram_addr),
    .ram_read_data_i(ram_rd), .nrzi_o(nrzi), .read_frame_idx_o(r_idx),
    .frame_start_o(fs), .underrun_o(ur), .busy_o(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int fs_cnt   = 0;
  int ur_cnt   = 0;

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // sample table and the 1-bit RAM holding it (bit b = sample bit 23-b)
  logic [23:0] smp [8][8];
  logic        mem [2048];

  always @(posedge clk) ram_rd <= mem[ram_addr];

  // behavioural model
  int       ph, fcyc;
  bit       in_fr;
  logic     nrzi_m, fs_m, ur_m;
  logic [CB-1:0] idx_m;
  bit       fbits [256];

  task automatic build_frame(input bit mute, input logic [3:0] ub, input logic [CB-1:0] f);
    int k;
    k = 0;
    for (int i = 0; i < 10; i++) fbits[k++] = 1'b0;
    fbits[k++] = 1'b1;
    for (int i = 3; i >= 0; i--) fbits[k++] = ub[i];
    fbits[k++] = 1'b1;
    for (int c = 0; c < 8; c++)
      for (int g = 0; g < 6; g++) begin
        for (int j = 0; j < 4; j++) fbits[k++] = mute ? 1'b0 : smp[f][c][23 - (g * 4 + j)];
        fbits[k++] = 1'b1;
      end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; fcyc = 0; in_fr = 0; nrzi_m = 0; fs_m = 0; ur_m = 0; idx_m = '0;
    end else begin
      bit mute;
      fs_m = 0;
      ur_m = 0;
      if (in_fr && fcyc < FRAME_CYC - 1) fcyc++;
      else if (ph == C - 1) begin
        if (tx_en) begin
          fs_m = 1; in_fr = 1; fcyc = 0;
          if (idx_m != w_idx) begin idx_m = idx_m + 1'b1; mute = 1'b0; end
          else begin ur_m = 1; mute = MUTE; end
          build_frame(mute, user_bits, idx_m);
        end else in_fr = 0;
      end
      if (in_fr && (fcyc % C) == 0) nrzi_m = nrzi_m ^ fbits[fcyc / C];
      ph = (ph == C - 1) ? 0 : ph + 1;
    end
  end

  // scoreboard: compare every cycle away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("nrzi", nrzi, nrzi_m);
      chk("frame_start", fs, fs_m);
      chk("underrun", ur, ur_m);
      chk("busy", busy, in_fr);
      chk("read_idx", r_idx, idx_m);
      if (fs) fs_cnt++;
      if (ur) ur_cnt++;
    end
  end

  function automatic logic [4:0] fb5(int s);
    return {fbits[s], fbits[s+1], fbits[s+2], fbits[s+3], fbits[s+4]};
  endfunction

  function automatic int ones();
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) n += fbits[i];
    return n;
  endfunction

  // driver tasks
  task automatic wait_fs();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!fs && n < 3000);
    chk("frame_start_seen", fs, 1);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_nrzi"}, nrzi, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_idx"}, r_idx, 0);
    chk({tag, "_fs"}, fs, 0);
    chk({tag, "_ur"}, ur, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int t, first, e, got;
    logic lvl;
    rst_n = 0; tx_en = 0; user_bits = 0; w_idx = 0;
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 8; c++) smp[f][c] = 24'($urandom);
    for (int c = 0; c < 8; c++) smp[1][c] = 24'h0;
    smp[1][0] = 24'h800001;
    smp[1][7] = 24'hA5A5A5;
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 8; c++)
        for (int b = 0; b < 32; b++)
          mem[f * 256 + c * 32 + b] = (b < 24) ? smp[f][c][23 - b] : 1'($urandom);

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1;

    // idle with tx disabled
    repeat (2000) @(negedge clk);
    chk("idle_fs_count", fs_cnt, 0);
    chk("idle_nrzi", nrzi, 0);

    // first frame: frame 1, user 1010
    w_idx = 1; user_bits = 4'b1010; tx_en = 1;
    wait_fs();
    chk("first_idx", r_idx, 1);
    chk("first_underrun", ur, 0);
    chk("pin_sync", fb5(6), 5'b00001);
    chk("pin_user", fb5(11), 5'b10101);
    chk("pin_ch0_g0", fb5(16), 5'b10001);
    chk("pin_ch0_g5", fb5(41), 5'b00011);
    chk("pin_ch7_g0", fb5(226), 5'b10101);
    chk("pin_ch7_g5", fb5(251), 5'b01011);
    chk("pin_ones", ones(), 66);
    lvl = nrzi; t = 0; first = -1;
    do begin
      @(negedge clk); t++;
      if (first < 0 && nrzi !== lvl) first = t;
    end while (!fs && t < 2000);
    chk("sync_first_toggle", first, 40);
    chk("frame_period", t, 1024);

    // second frame: no new frame available
    chk("second_underrun", ur, 1);
    chk("second_idx", r_idx, 1);
    chk("pin_mute_ch7_g0", fb5(226), MUTE ? 5'b00001 : 5'b10101);
    chk("pin_mute_ones", ones(), MUTE ? 52 : 66);

    // wrap-around: producer stays one frame ahead
    w_idx = 2; user_bits = 4'($urandom);
    e = 2;
    for (int i = 0; i < 10; i++) begin
      wait_fs();
      chk("wrap_idx", r_idx, e);
      chk("wrap_underrun", ur, 0);
      e = (e + 1) % 8;
      w_idx = w_idx + 1'b1;
      user_bits = 4'($urandom);
    end
    chk("wrap_ur_total", ur_cnt, 1);

    // random producer pacing, with one mid-frame stop
    for (int i = 0; i < 8; i++) begin
      wait_fs();
      if ($urandom_range(0, 1) == 1) w_idx = w_idx + 1'b1;
      user_bits = 4'($urandom);
      if (i == 4) begin
        repeat ($urandom_range(50, 500)) @(negedge clk);
        tx_en = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (busy && t < 1100);
        chk("stop_completes", busy, 0);
        repeat ($urandom_range(10, 300)) @(negedge clk);
        tx_en = 1;
      end
    end

    // reset in the middle of DATA
    wait_fs();
    repeat (200) @(negedge clk);
    #2 rst_n = 0;
    #1 chk_reset_vals("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    got = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (fs) begin got = k; break; end
    end
    chk("restart_latency", got, C);
    chk("restart_idx", r_idx, 1);
    wait_fs();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
